// File: rtl/dict_pkg.sv
// Shared definitions for dictionary loaders: per-field-type widths and the loader state encoding.
package dict_pkg;

  localparam int R_KEY_WIDTH = 8;
  localparam int R_VAL_WIDTH = 15;
  localparam int I_KEY_WIDTH = 7;
  localparam int I_VAL_WIDTH = 13;

  localparam int DICT_ENTRIES = 2 ** I_KEY_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BURST,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic int dict_entries(input int key_width);
    return 1 << key_width;
  endfunction

endpackage

// File: rtl/dict_loader_fifo.sv
// Prefetch FIFO: first-word fall-through, zero-latency pop, push ignored when full unless popping.
// Flush drops all contents in one cycle and wins over a same-cycle push.
module dict_loader_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dict_loader.sv
// Boot-time loader streaming a memory image into a dictionary field as one contiguous write burst,
// restarting on prefetch underrun; DICT_LOADER_CHECKSUM_EN adds a trailing checksum-word verify.
module dict_loader
  import dict_pkg::*;
#(
  parameter int KEY_WIDTH   = I_KEY_WIDTH,
  parameter int VAL_WIDTH   = I_VAL_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  output logic                 mem_valid,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic                 write_enable,
  output logic [VAL_WIDTH-1:0] write_val,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 checksum_err
);
  localparam int CW = KEY_WIDTH + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] N_ENTRIES   = CW'(dict_entries(KEY_WIDTH));
  localparam logic [LW-1:0] FIFO_CAP    = LW'(FIFO_DEPTH);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  state_t               state, state_nxt;
  logic [CW-1:0]        fetch_idx, fetch_idx_nxt;
  logic [CW-1:0]        wr_cnt, wr_cnt_nxt;
  logic [RW-1:0]        retry_cnt, retry_nxt;
  logic [31:0]          base, base_nxt;
  logic [31:0]          mem_addr_nxt;
  logic                 mem_valid_nxt, we_nxt, done_nxt, error_nxt, issue;
  logic [VAL_WIDTH-1:0] wv_nxt;
  logic                 ready_hit, push, pop, flush, full, empty;
  logic [LW-1:0]        level, level_nxt;
  logic [VAL_WIDTH-1:0] head;

  assign ready_hit = mem_valid && mem_ready;
  assign push      = ready_hit && (state == ST_FETCH || state == ST_BURST) && (fetch_idx < N_ENTRIES);
  assign busy      = (state == ST_FETCH) || (state == ST_BURST) || (state == ST_DRAIN) || (state == ST_CHECK);

  dict_loader_fifo #(.WIDTH(VAL_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_rdata[VAL_WIDTH-1:0]),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_comb begin
    state_nxt     = state;
    fetch_idx_nxt = push ? fetch_idx + CW'(1) : fetch_idx;
    wr_cnt_nxt    = wr_cnt;
    retry_nxt     = retry_cnt;
    base_nxt      = base;
    done_nxt      = done;
    error_nxt     = error;
    we_nxt        = 1'b0;
    wv_nxt        = write_val;
    pop           = 1'b0;
    flush         = 1'b0;

    case (state)
      // A read still held from an aborted load must retire before a new load reuses the bus.
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start && !mem_valid) begin
          state_nxt     = ST_FETCH;
          fetch_idx_nxt = '0;
          wr_cnt_nxt    = '0;
          retry_nxt     = '0;
          base_nxt      = base_addr;
          done_nxt      = 1'b0;
          error_nxt     = 1'b0;
        end
      end
      ST_FETCH: begin
        if (full || fetch_idx == N_ENTRIES) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (wr_cnt == N_ENTRIES) begin
`ifdef DICT_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
`endif
        end else if (empty) begin
          flush     = 1'b1;
          retry_nxt = retry_cnt + RW'(1);
          if (retry_nxt == RETRY_LIMIT) begin
            state_nxt = ST_FAIL;
            error_nxt = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          pop        = 1'b1;
          we_nxt     = 1'b1;
          wv_nxt     = head;
          wr_cnt_nxt = wr_cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!mem_valid || mem_ready) begin
          state_nxt     = ST_FETCH;
          fetch_idx_nxt = '0;
          wr_cnt_nxt    = '0;
        end
      end
`ifdef DICT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (ready_hit) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    // Look ahead one cycle so reads run back-to-back without overrunning the FIFO.
    level_nxt = flush ? '0 : level + LW'(push) - LW'(pop);
    issue     = 1'b0;
    if (!mem_valid || mem_ready) begin
      if ((state_nxt == ST_FETCH || state_nxt == ST_BURST) &&
          fetch_idx_nxt < N_ENTRIES && level_nxt < FIFO_CAP)
        issue = 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
      // fetch_idx sits at N_ENTRIES here, so the same address formula lands on the checksum word.
      if (state != ST_CHECK && state_nxt == ST_CHECK) issue = 1'b1;
`endif
    end
    mem_valid_nxt = issue || (mem_valid && !mem_ready);
    mem_addr_nxt  = issue ? base_nxt + (32'(fetch_idx_nxt) << 2) : mem_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      fetch_idx    <= '0;
      wr_cnt       <= '0;
      retry_cnt    <= '0;
      base         <= '0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      write_enable <= 1'b0;
      write_val    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_idx    <= fetch_idx_nxt;
      wr_cnt       <= wr_cnt_nxt;
      retry_cnt    <= retry_nxt;
      base         <= base_nxt;
      mem_valid    <= mem_valid_nxt;
      mem_addr     <= mem_addr_nxt;
      write_enable <= we_nxt;
      write_val    <= wv_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
    end
  end

`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        load_begin;
  logic        attempt_begin;

  assign attempt_begin = (state_nxt == ST_FETCH) && (state != ST_FETCH);
  assign load_begin    = attempt_begin && (state != ST_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum          <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (attempt_begin) sum <= '0;
      else if (pop)      sum <= sum + 32'(head);
      if (load_begin)                          checksum_err <= 1'b0;
      else if (state == ST_CHECK && ready_hit) checksum_err <= (sum != mem_rdata);
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:VAL_WIDTH];
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader: memory responder, shadow field and a write-value scoreboard.
module tb_dict_loader;
  localparam int          N    = 128;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = BASE;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata;
  logic        write_enable;
  logic [12:0] write_val;
  logic        busy, done, error, checksum_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_img [256];
  logic [12:0] shadow [N];
  logic [12:0] exp_q[$];
  logic [12:0] replay_q[$];
  logic [31:0] addr_log[$];
  logic [12:0] exp_w;
  int fidx = 0, run_len = 0, last_run = 0, short_runs = 0;
  int cyc = 0, mode = 0, stall_lo = 0, stall_hi = 0;
  int n, bad;

  dict_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .write_enable (write_enable),
    .write_val    (write_val),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .checksum_err (checksum_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder; ready is deliberately not gated by mem_valid.
  always_comb begin
    case (mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 3) == 0;
      default: mem_ready = !(cyc >= stall_lo && cyc < stall_hi);
    endcase
  end
  assign mem_rdata = mem_img[mem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shadow dictionary field plus scoreboard; an aborted burst replays its expectations.
  always @(negedge clk) begin
    if (mem_valid && mem_ready) addr_log.push_back(mem_addr);
    if (write_enable) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else                   exp_w = 'x;
      replay_q.push_back(exp_w);
      check("write_val", 32'(write_val), 32'(exp_w));
      if (fidx < N) shadow[fidx] = write_val;
      fidx++;
      run_len++;
    end else begin
      if (run_len != 0) begin
        if (run_len < N) begin
          short_runs++;
          exp_q = {replay_q, exp_q};
        end
        last_run = run_len;
        replay_q.delete();
      end
      run_len = 0;
      fidx    = 0;
    end
  end

  task automatic load_image(input logic [15:0] upper, input int cs_bias);
    int cs = 0;
    for (int k = 0; k < N; k++) begin
      mem_img[k] = {upper, 16'(16'h100 + k)};
      exp_q.push_back(13'(16'h100 + k));
      cs += 32'(13'(16'h100 + k));
    end
    mem_img[N] = 32'(cs + cs_bias);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_loaded(input string tag, input logic cs_err);
    int miss = 0;
    for (int k = 0; k < N; k++)
      if (shadow[k] !== 13'(16'h100 + k)) miss++;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_burst_len"}, 32'(last_run), 32'(N));
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_field_miss"}, 32'(miss), 32'd0);
    check({tag, "_cs_err"}, 32'(checksum_err), 32'(cs_err));
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem_img[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cs_err", 32'(checksum_err), 32'd0);
    reset = 1'b0;

    // Zero-wait memory: one clean 128-write burst.
    mode = 0;
    load_image(16'h0000, 0);
    pulse_start();
    check("zw_busy", 32'(busy), 32'd1);
    wait_idle("zw");
    check_loaded("zw", 1'b0);

    // Ready every third cycle: three underruns then failure.
    exp_q.delete();
    short_runs = 0;
    mode = 1;
    load_image(16'h0000, 0);
    pulse_start();
    wait_idle("slow");
    check("slow_error", 32'(error), 32'd1);
    check("slow_done", 32'(done), 32'd0);
    check("slow_busy", 32'(busy), 32'd0);
    check("slow_underruns", 32'(short_runs), 32'd3);
    mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Stall window inside the first attempt only: one retry, then a clean load.
    exp_q.delete();
    short_runs = 0;
    load_image(16'h0000, 0);
    stall_lo = cyc + 16;
    stall_hi = cyc + 46;
    mode = 2;
    pulse_start();
    wait_idle("stall");
    check("stall_underruns", 32'(short_runs), 32'd1);
    check_loaded("stall", 1'b0);
    mode = 0;

    // Start pulses while busy and junk upper data bits.
    exp_q.delete();
    addr_log.delete();
    load_image(16'hFFFF, 0);
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    repeat (30) @(posedge clk);
    pulse_start();
    wait_idle("busy_start");
    check_loaded("busy_start", 1'b0);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (k >= addr_log.size() || addr_log[k] !== BASE + 32'(4 * k)) bad++;
    check("addr_seq_bad", 32'(bad), 32'd0);
`ifdef DICT_LOADER_CHECKSUM_EN
    check("addr_count", 32'(addr_log.size()), 32'(N + 1));
`else
    check("addr_count", 32'(addr_log.size()), 32'(N));
`endif

    // Reset in the middle of a burst, then a full reload.
    exp_q.delete();
    load_image(16'h0000, 0);
    pulse_start();
    n = 0;
    while (run_len < 40 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_reached", 32'(run_len >= 40), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    replay_q.delete();
    load_image(16'h0000, 0);
    pulse_start();
    wait_idle("reload");
    check_loaded("reload", 1'b0);

`ifdef DICT_LOADER_CHECKSUM_EN
    // Checksum word deliberately off by one.
    exp_q.delete();
    load_image(16'h0000, 1);
    pulse_start();
    wait_idle("cs_bad");
    check_loaded("cs_bad", 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
